// File: rtl/tsc_mem_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tsc_mem_port_ctrl_if
// Brief    : Requester + memory-port bundle for the TSC memory port controller.
// Revision : 1.0
// ============================================================================
interface tsc_mem_port_ctrl_if #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_W     = 16
);
    logic                 fetch_req;
    logic [WORD_SIZE-1:0] fetch_addr;
    logic [WORD_SIZE-1:0] fetch_inst;
    logic                 fetch_done;
    logic                 data_req;
    logic                 data_we;
    logic [WORD_SIZE-1:0] data_addr;
    logic [WORD_SIZE-1:0] data_wdata;
    logic [WORD_SIZE-1:0] data_rdata;
    logic                 data_done;
    logic                 err;
    logic                 busy;
    logic [CNT_W-1:0]     num_inst;
    logic [WORD_SIZE-1:0] address;
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic                 mem_oe;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 inputReady;
    logic                 ackOutput;

    modport master (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               mem_rdata, inputReady, ackOutput,
        output fetch_inst, fetch_done, data_rdata, data_done, err, busy, num_inst,
               address, readM, writeM, mem_wdata, mem_oe
    );

    modport slave (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               mem_rdata, inputReady, ackOutput,
        input  fetch_inst, fetch_done, data_rdata, data_done, err, busy, num_inst,
               address, readM, writeM, mem_wdata, mem_oe
    );
endinterface
`default_nettype wire

// File: rtl/tsc_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tsc_mem_port_ctrl
// Brief    : Shared memory port arbiter/sequencer for fetch and load/store.
// Revision : 1.0
// ============================================================================
module tsc_mem_port_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 15,
    parameter int CNT_W     = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    tsc_mem_port_ctrl_if.master bus
);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DREAD  = 3'd2;
    localparam logic [2:0] c_DWRITE = 3'd3;
    localparam logic [2:0] c_GAP    = 3'd4;

    localparam int                 c_TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LIM = c_TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 w_in_access;
    logic                 w_hs;
    logic                 w_tmo;

    logic                 r_readM,      w_readM_d;
    logic                 r_writeM,     w_writeM_d;
    logic                 r_mem_oe,     w_mem_oe_d;
    logic                 r_busy,       w_busy_d;
    logic                 r_fetch_done, w_fetch_done_d;
    logic                 r_data_done,  w_data_done_d;
    logic                 r_err,        w_err_d;
    logic [WORD_SIZE-1:0] r_address,    w_address_d;
    logic [WORD_SIZE-1:0] r_mem_wdata,  w_mem_wdata_d;
    logic [WORD_SIZE-1:0] r_fetch_inst, w_fetch_inst_d;
    logic [WORD_SIZE-1:0] r_data_rdata, w_data_rdata_d;
    logic [CNT_W-1:0]     r_num_inst,   w_num_inst_d;

    assign w_in_access = (r_state == c_FETCH) || (r_state == c_DREAD) || (r_state == c_DWRITE);
    // Only the handshake that matches the current access direction counts.
    assign w_hs  = ((r_state == c_FETCH || r_state == c_DREAD) && bus.inputReady) ||
                   ((r_state == c_DWRITE) && bus.ackOutput);
    assign w_tmo = (TIMEOUT > 0) && w_in_access && !w_hs && (r_tmo_cnt == c_TMO_LIM);

    // State register and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_access && (w_next_state == r_state) && (TIMEOUT > 0))
                r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
            else
                r_tmo_cnt <= '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.data_req)
                    w_next_state = bus.data_we ? c_DWRITE : c_DREAD;
                else if (bus.fetch_req)
                    w_next_state = c_FETCH;
            end
            c_FETCH, c_DREAD, c_DWRITE: begin
                if (w_hs || w_tmo)
                    w_next_state = c_GAP;
            end
            c_GAP:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output logic: next values of every registered output
    always_comb begin
        w_readM_d      = (w_next_state == c_FETCH) || (w_next_state == c_DREAD);
        w_writeM_d     = (w_next_state == c_DWRITE);
        w_mem_oe_d     = (w_next_state == c_DWRITE);
        w_busy_d       = (w_next_state != c_IDLE);
        w_fetch_done_d = (r_state == c_FETCH) && w_hs;
        w_data_done_d  = ((r_state == c_DREAD) || (r_state == c_DWRITE)) && w_hs;
        w_err_d        = w_tmo;

        w_address_d = r_address;
        if (w_next_state == c_IDLE)
            w_address_d = '0;
        else if (r_state == c_IDLE)
            w_address_d = bus.data_req ? bus.data_addr : bus.fetch_addr;

        w_mem_wdata_d  = (r_state == c_IDLE && bus.data_req) ? bus.data_wdata : r_mem_wdata;
        w_fetch_inst_d = w_fetch_done_d ? bus.mem_rdata : r_fetch_inst;
        w_data_rdata_d = ((r_state == c_DREAD) && w_hs) ? bus.mem_rdata : r_data_rdata;
        w_num_inst_d   = w_fetch_done_d ? r_num_inst + CNT_W'(1) : r_num_inst;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readM      <= 1'b0;
            r_writeM     <= 1'b0;
            r_mem_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_err        <= 1'b0;
            r_address    <= '0;
            r_mem_wdata  <= '0;
            r_fetch_inst <= '0;
            r_data_rdata <= '0;
            r_num_inst   <= '0;
        end else begin
            r_readM      <= w_readM_d;
            r_writeM     <= w_writeM_d;
            r_mem_oe     <= w_mem_oe_d;
            r_busy       <= w_busy_d;
            r_fetch_done <= w_fetch_done_d;
            r_data_done  <= w_data_done_d;
            r_err        <= w_err_d;
            r_address    <= w_address_d;
            r_mem_wdata  <= w_mem_wdata_d;
            r_fetch_inst <= w_fetch_inst_d;
            r_data_rdata <= w_data_rdata_d;
            r_num_inst   <= w_num_inst_d;
        end
    end

    assign bus.readM      = r_readM;
    assign bus.writeM     = r_writeM;
    assign bus.mem_oe     = r_mem_oe;
    assign bus.busy       = r_busy;
    assign bus.fetch_done = r_fetch_done;
    assign bus.data_done  = r_data_done;
    assign bus.err        = r_err;
    assign bus.address    = r_address;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.fetch_inst = r_fetch_inst;
    assign bus.data_rdata = r_data_rdata;
    assign bus.num_inst   = r_num_inst;
endmodule
`default_nettype wire

// File: tb/tb_tsc_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tsc_mem_port_ctrl
// Brief    : Randomised self-checking bench for tsc_mem_port_ctrl.
// Revision : 1.0
// ============================================================================
module tb_tsc_mem_port_ctrl;
    localparam int W   = 16;
    localparam int TMO = 4;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0]  exp_inst;
    logic [W-1:0]  exp_drd;
    logic [CW-1:0] exp_cnt;

    tsc_mem_port_ctrl_if #(.WORD_SIZE(W), .CNT_W(CW)) bus ();

    tsc_mem_port_ctrl #(.WORD_SIZE(W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One access from request to idle. Called at a negedge with the DUT idle.
    // dly = wait edges before the handshake; dly >= TMO means it never comes.
    task automatic run_access(input bit is_data, input bit we, input logic [W-1:0] addr,
                              input logic [W-1:0] wd, input logic [W-1:0] rd,
                              input int dly, input bit hold_fetch);
        bit       rd_acc;
        bit       ok;
        int       n_strobe;
        logic [6:0] act;
        logic [6:0] exp;
        rd_acc   = !(is_data && we);
        ok       = (dly < TMO);
        n_strobe = ok ? dly + 1 : TMO;
        if (is_data) begin
            bus.data_req = 1'b1; bus.data_we = we; bus.data_addr = addr; bus.data_wdata = wd;
        end else begin
            bus.fetch_req = 1'b1; bus.fetch_addr = addr;
        end
        bus.inputReady = 1'($urandom);
        bus.ackOutput  = 1'($urandom);
        bus.mem_rdata  = W'($urandom);
        for (int k = 0; k < n_strobe; k++) begin
            @(negedge clk);
            act = {bus.readM, bus.writeM, bus.mem_oe, bus.busy, bus.fetch_done, bus.data_done, bus.err};
            exp = {rd_acc, !rd_acc, !rd_acc, 1'b1, 3'b000};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL access_strobes k=%0d: got %b want %b", k, act, exp);
            end
            n_tests++;
            if (bus.address !== addr) begin
                n_fail++;
                $display("FAIL access_address k=%0d: got %h want %h", k, bus.address, addr);
            end
            if (!rd_acc) begin
                n_tests++;
                if (bus.mem_wdata !== wd) begin
                    n_fail++;
                    $display("FAIL access_wdata k=%0d: got %h want %h", k, bus.mem_wdata, wd);
                end
            end
            if (ok && k == dly) begin
                bus.inputReady = rd_acc;
                bus.ackOutput  = !rd_acc;
                bus.mem_rdata  = rd;
            end else begin
                bus.inputReady = rd_acc ? 1'b0 : 1'($urandom);
                bus.ackOutput  = rd_acc ? 1'($urandom) : 1'b0;
                bus.mem_rdata  = W'($urandom);
            end
        end
        @(negedge clk);
        if (ok) begin
            if (!is_data) begin
                exp_inst = rd;
                exp_cnt  = exp_cnt + 1'b1;
            end else if (!we) begin
                exp_drd = rd;
            end
        end
        act = {bus.readM, bus.writeM, bus.mem_oe, bus.busy, bus.fetch_done, bus.data_done, bus.err};
        exp = {3'b000, 1'b1, ok && !is_data, ok && is_data, !ok};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL access_end: got %b want %b", act, exp);
        end
        n_tests++;
        if (bus.fetch_inst !== exp_inst) begin
            n_fail++;
            $display("FAIL fetch_inst: got %h want %h", bus.fetch_inst, exp_inst);
        end
        n_tests++;
        if (bus.data_rdata !== exp_drd) begin
            n_fail++;
            $display("FAIL data_rdata: got %h want %h", bus.data_rdata, exp_drd);
        end
        n_tests++;
        if (bus.num_inst !== exp_cnt) begin
            n_fail++;
            $display("FAIL num_inst: got %0d want %0d", bus.num_inst, exp_cnt);
        end
        if (is_data) bus.data_req = 1'b0;
        if (!(is_data && hold_fetch)) bus.fetch_req = 1'b0;
        bus.inputReady = 1'($urandom);
        bus.ackOutput  = 1'($urandom);
        bus.mem_rdata  = W'($urandom);
        @(negedge clk);
        act = {bus.readM, bus.writeM, bus.mem_oe, bus.busy, bus.fetch_done, bus.data_done, bus.err};
        n_tests++;
        if (act !== 7'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b want 0000000", act);
        end
        n_tests++;
        if (bus.address !== '0) begin
            n_fail++;
            $display("FAIL idle_address: got %h want 0000", bus.address);
        end
        bus.inputReady = 1'b0;
        bus.ackOutput  = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] act;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        act = {bus.readM, bus.writeM, bus.mem_oe, bus.busy, bus.fetch_done, bus.data_done, bus.err};
        n_tests++;
        if (act !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000", act);
        end
        n_tests++;
        if ({bus.address, bus.mem_wdata, bus.fetch_inst, bus.data_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h want zeros", bus.address, bus.mem_wdata,
                     bus.fetch_inst, bus.data_rdata);
        end
        n_tests++;
        if (bus.num_inst !== '0) begin
            n_fail++;
            $display("FAIL reset_num_inst: got %0d want 0", bus.num_inst);
        end
        reset    = 1'b0;
        exp_inst = '0;
        exp_drd  = '0;
        exp_cnt  = '0;
        @(negedge clk);
    endtask

    task automatic test_fetch;
        run_access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h6A05, 2, 1'b0);
    endtask

    task automatic test_priority;
        logic [W-1:0] fa;
        fa = W'($urandom);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = fa;
        run_access(1'b1, 1'b0, 16'h0040, 16'h0000, W'($urandom), $urandom_range(0, 2), 1'b1);
        run_access(1'b0, 1'b0, fa, 16'h0000, W'($urandom), $urandom_range(0, 2), 1'b0);
    endtask

    task automatic test_store;
        run_access(1'b1, 1'b1, 16'h0041, 16'hBEEF, 16'h0000, 1, 1'b0);
    endtask

    task automatic test_timeout;
        run_access(1'b0, 1'b0, W'($urandom), 16'h0000, W'($urandom), TMO, 1'b0);
        run_access(1'b0, 1'b0, W'($urandom), 16'h0000, W'($urandom), TMO - 1, 1'b0);
        run_access(1'b1, 1'b0, W'($urandom), 16'h0000, W'($urandom), TMO + 2, 1'b0);
        run_access(1'b1, 1'b1, W'($urandom), W'($urandom), 16'h0000, TMO, 1'b0);
    endtask

    task automatic test_random;
        int kind;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            run_access(kind != 0, kind == 2, W'($urandom), W'($urandom), W'($urandom),
                       $urandom_range(0, TMO + 1), 1'b0);
        end
    endtask

    task automatic test_wrap;
        int guard;
        guard = 0;
        do begin
            run_access(1'b0, 1'b0, W'($urandom), 16'h0000, W'($urandom), $urandom_range(0, TMO - 1), 1'b0);
            guard++;
        end while (exp_cnt != '0 && guard < 40);
        n_tests++;
        if (bus.num_inst !== exp_cnt) begin
            n_fail++;
            $display("FAIL wrap_num_inst: got %0d want %0d", bus.num_inst, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_write;
        run_access(1'b0, 1'b0, W'($urandom), 16'h0000, W'($urandom), 0, 1'b0);
        bus.data_req = 1'b1; bus.data_we = 1'b1;
        bus.data_addr = W'($urandom); bus.data_wdata = W'($urandom);
        @(negedge clk);
        n_tests++;
        if ({bus.writeM, bus.mem_oe, bus.busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL midwrite_active: got %b want 111", {bus.writeM, bus.mem_oe, bus.busy});
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({bus.writeM, bus.mem_oe, bus.busy, bus.readM} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset_ctrl: got %b want 0000", {bus.writeM, bus.mem_oe, bus.busy, bus.readM});
        end
        n_tests++;
        if (bus.num_inst !== '0 || bus.address !== '0) begin
            n_fail++;
            $display("FAIL async_reset_state: got num_inst %0d addr %h want 0 0000", bus.num_inst, bus.address);
        end
        bus.data_req = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        exp_inst = '0;
        exp_drd  = '0;
        exp_cnt  = '0;
        @(negedge clk);
        run_access(1'b0, 1'b0, W'($urandom), 16'h0000, W'($urandom), 1, 1'b0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.mem_rdata  = '0;
        bus.inputReady = 1'b0;
        bus.ackOutput  = 1'b0;
        exp_inst       = '0;
        exp_drd        = '0;
        exp_cnt        = '0;
        test_reset;
        test_fetch;
        test_priority;
        test_store;
        test_timeout;
        test_random;
        test_wrap;
        test_reset_mid_write;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
